// File: rtl/wishbone_nn_master_if.sv
// Bundle of the command, Wishbone and response signals of wishbone_nn_master.
// The master modport is the block's view; the slave modport is the environment's view.
interface wishbone_nn_master_if;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        busy_o;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  wbm_ack_i, wbm_dat_i, rsp_ready_i,
        output cmd_ready_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
        output wbm_adr_o, wbm_dat_o, rsp_valid_o, rsp_dat_o, rsp_err_o, busy_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output wbm_ack_i, wbm_dat_i, rsp_ready_i,
        input  cmd_ready_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
        input  wbm_adr_o, wbm_dat_o, rsp_valid_o, rsp_dat_o, rsp_err_o, busy_o
    );
endinterface

// File: rtl/wishbone_nn_master.sv
// Wishbone classic single-transfer initiator: one command in, one stb/cyc cycle, one response out.
// Optional ack timeout abort is built when WB_MASTER_TIMEOUT_EN is defined.
module wishbone_nn_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    wishbone_nn_master_if.master       bus,
    output logic [1:0]                 dbg_state_o
);

    // Handshakes: a command transfers on a clock edge where cmd_valid_i & cmd_ready_o,
    // a response on an edge where rsp_valid_o & rsp_ready_i; valid holds its payload until then.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]  state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic        timeout_hit;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int unsigned       CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    // The count never exceeds TIMEOUT_CYCLES-1 in BUS, so the increment cannot wrap.
    always_comb begin
        cnt_inc     = cnt_q + CNT_W'(1);
        timeout_hit = (state_q == ST_BUS) && !bus.wbm_ack_i && (cnt_inc == CNT_LIMIT);
        cnt_d       = cnt_q;
        if (state_q != ST_BUS) begin
            cnt_d = '0;
        end else if (!bus.wbm_ack_i) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid_i) begin
                    we_d        = bus.cmd_we_i;
                    sel_d       = bus.cmd_sel_i;
                    adr_d       = bus.cmd_adr_i;
                    wdat_d      = bus.cmd_dat_i;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_BUS;
                end
            end
            ST_BUS: begin
                // An ack in the limit cycle still completes the transfer normally.
                if (bus.wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? 32'd0 : bus.wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RESP;
                end else if (timeout_hit) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = 32'd0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'd0;
            adr_q       <= 32'd0;
            wdat_q      <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'd0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cmd_ready_o = cmd_ready_q;
    assign bus.wbm_cyc_o   = cyc_q;
    assign bus.wbm_stb_o   = stb_q;
    assign bus.wbm_we_o    = we_q;
    assign bus.wbm_sel_o   = sel_q;
    assign bus.wbm_adr_o   = adr_q;
    assign bus.wbm_dat_o   = wdat_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_dat_o   = rsp_dat_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.busy_o      = busy_q;
    assign dbg_state_o     = state_q;

endmodule
